config_sequencer: RTL and testbench

CONFIG_SEQUENCER -- requirements
Module: config_sequencer

---
 rtl/mdc_cfg_pkg.sv | 15 +
 rtl/cfg_down_counter.sv | 31 +++
 rtl/config_sequencer.sv | 146 ++++++++++++++
 tb/tb_config_sequencer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mdc_cfg_pkg.sv
// Shared definitions for the configuration sequencer: FSM state encoding,
// default ID width and the reserved "no configuration" ID.
package mdc_cfg_pkg;

    localparam int DEFAULT_ID_WIDTH = 8;
    localparam int INVALID_ID       = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_SWITCH = 2'd2,
        ST_SETTLE = 2'd3
    } cfg_state_e;

endpackage

// File: rtl/cfg_down_counter.sv
// Loadable down counter with zero flag; reused for the drain timeout and the
// settle countdown since the two phases never overlap.
module cfg_down_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic             zero
);

    logic [WIDTH-1:0] count_r;

    // Count register: load wins over decrement, saturates at zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_r <= {WIDTH{1'b0}};
        end else if (load) begin
            count_r <= load_value;
        end else if (enable && (count_r != {WIDTH{1'b0}})) begin
            count_r <= count_r - WIDTH'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == {WIDTH{1'b0}});

endmodule

// File: rtl/config_sequencer.sv
// Sequences a configuration-ID change: stalls the datapath, waits for it to
// drain, switches the ID, lets it settle, then releases the datapath.
module config_sequencer
    import mdc_cfg_pkg::*;
#(
    parameter int ID_WIDTH      = DEFAULT_ID_WIDTH,
    parameter int NUM_CFG       = 2,
    parameter int RESET_ID      = 1,
    parameter int SETTLE_CYCLES = 2,
    parameter int DRAIN_TIMEOUT = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [ID_WIDTH-1:0] req_id,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                dp_idle,
    output logic                dp_hold,
    output logic [ID_WIDTH-1:0] ID,
    output logic                busy,
    output logic                cfg_done,
    output logic                cfg_err
);

    localparam int CNT_MAX   = (DRAIN_TIMEOUT > SETTLE_CYCLES) ? DRAIN_TIMEOUT - 1 : SETTLE_CYCLES - 1;
    localparam int CNT_WIDTH = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

    localparam logic [CNT_WIDTH-1:0] DRAIN_LOAD  = CNT_WIDTH'(DRAIN_TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] SETTLE_LOAD = CNT_WIDTH'(SETTLE_CYCLES - 1);
    localparam logic [ID_WIDTH-1:0]  RST_ID      = ID_WIDTH'(RESET_ID);
    localparam logic [ID_WIDTH-1:0]  MAX_ID      = ID_WIDTH'(NUM_CFG);
    localparam logic [ID_WIDTH-1:0]  NULL_ID     = ID_WIDTH'(INVALID_ID);

    cfg_state_e            state_r, state_next_s;
    logic [ID_WIDTH-1:0]   id_r, id_next_s;
    logic [ID_WIDTH-1:0]   pending_r, pending_next_s;
    logic                  cfg_done_r, done_next_s;
    logic                  cfg_err_r, err_next_s;
    logic                  dp_hold_r, busy_r, req_ready_r;
    logic                  cnt_load_s, cnt_en_s, cnt_zero_s;
    logic [CNT_WIDTH-1:0]  cnt_load_val_s;
    logic                  id_valid_s;

    assign id_valid_s = (req_id != NULL_ID) && (req_id <= MAX_ID);

    cfg_down_counter #(
        .WIDTH(CNT_WIDTH)
    ) u_counter (
        .clock      (clock),
        .reset      (reset),
        .load       (cnt_load_s),
        .load_value (cnt_load_val_s),
        .enable     (cnt_en_s),
        .zero       (cnt_zero_s)
    );

    // Next-state, next-ID and pulse decode.
    always_comb begin
        state_next_s   = state_r;
        id_next_s      = id_r;
        pending_next_s = pending_r;
        done_next_s    = 1'b0;
        err_next_s     = 1'b0;
        cnt_load_s     = 1'b0;
        cnt_load_val_s = {CNT_WIDTH{1'b0}};
        cnt_en_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    if (!id_valid_s) begin
                        err_next_s = 1'b1;
                    end else if (req_id == id_r) begin
                        done_next_s = 1'b1;
                    end else begin
                        pending_next_s = req_id;
                        state_next_s   = ST_DRAIN;
                        cnt_load_s     = 1'b1;
                        cnt_load_val_s = DRAIN_LOAD;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                // Idle datapath takes priority over an expiring timeout.
                if (dp_idle) begin
                    state_next_s = ST_SWITCH;
                end else if (cnt_zero_s) begin
                    state_next_s = ST_IDLE;
                    err_next_s   = 1'b1;
                end else begin
                    cnt_en_s = 1'b1;
                end
            end
            ST_SWITCH: begin
                id_next_s      = pending_r;
                cnt_load_s     = 1'b1;
                cnt_load_val_s = SETTLE_LOAD;
                state_next_s   = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_zero_s) begin
                    state_next_s = ST_IDLE;
                    done_next_s  = 1'b1;
                end else begin
                    cnt_en_s = 1'b1;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State, ID and output registers; status flags track the next state so
    // they line up with the state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            id_r        <= RST_ID;
            pending_r   <= RST_ID;
            cfg_done_r  <= 1'b0;
            cfg_err_r   <= 1'b0;
            dp_hold_r   <= 1'b0;
            busy_r      <= 1'b0;
            req_ready_r <= 1'b1;
        end else begin
            state_r     <= state_next_s;
            id_r        <= id_next_s;
            pending_r   <= pending_next_s;
            cfg_done_r  <= done_next_s;
            cfg_err_r   <= err_next_s;
            dp_hold_r   <= (state_next_s != ST_IDLE);
            busy_r      <= (state_next_s != ST_IDLE);
            req_ready_r <= (state_next_s == ST_IDLE);
        end
    end

    assign req_ready = req_ready_r;
    assign dp_hold   = dp_hold_r;
    assign busy      = busy_r;
    assign ID        = id_r;
    assign cfg_done  = cfg_done_r;
    assign cfg_err   = cfg_err_r;

endmodule

// File: tb/tb_config_sequencer.sv
// Randomized self-checking bench for config_sequencer; expectations come from a
// timeline model derived from the request outcome and drain delay.
module tb_config_sequencer;

    localparam int ID_WIDTH      = 8;
    localparam int NUM_CFG       = 2;
    localparam int RESET_ID      = 1;
    localparam int SETTLE_CYCLES = 2;
    localparam int DRAIN_TIMEOUT = 16;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic [ID_WIDTH-1:0] req_id = '0;
    logic                req_valid = 1'b0;
    logic                req_ready;
    logic                dp_idle = 1'b0;
    logic                dp_hold;
    logic [ID_WIDTH-1:0] id_o;
    logic                busy;
    logic                cfg_done;
    logic                cfg_err;

    int checks = 0;
    int errors = 0;
    int model_id = RESET_ID;

    config_sequencer #(
        .ID_WIDTH(ID_WIDTH), .NUM_CFG(NUM_CFG), .RESET_ID(RESET_ID),
        .SETTLE_CYCLES(SETTLE_CYCLES), .DRAIN_TIMEOUT(DRAIN_TIMEOUT)
    ) dut (
        .clock(clock), .reset(reset), .req_id(req_id), .req_valid(req_valid),
        .req_ready(req_ready), .dp_idle(dp_idle), .dp_hold(dp_hold), .ID(id_o),
        .busy(busy), .cfg_done(cfg_done), .cfg_err(cfg_err)
    );

    always #5 clock = ~clock;

    // Issue one request from IDLE (called at a negedge) and check every cycle
    // until the sequencer is back in IDLE. Observation j is the value seen
    // between edges t+j-1 and t+j, where t is the handshake edge.
    task automatic run_req(input int rid, input int d, input string tag);
        int kind;
        int last;
        int old_id;
        logic [4:0] exp_v, obs_v;
        logic [ID_WIDTH-1:0] exp_id;
        logic e_hold, e_done, e_err;
        old_id = model_id;
        if (rid == 0 || rid > NUM_CFG) kind = 0;
        else if (rid == model_id)      kind = 1;
        else if (d < DRAIN_TIMEOUT)    kind = 2;
        else                           kind = 3;
        case (kind)
            0, 1:    last = 2;
            2:       last = 3 + d + SETTLE_CYCLES;
            default: last = DRAIN_TIMEOUT + 1;
        endcase
        req_id    = ID_WIDTH'(rid);
        req_valid = 1'b1;
        dp_idle   = 1'($urandom_range(1, 0));
        @(posedge clock);
        for (int j = 1; j <= last; j++) begin
            @(negedge clock);
            e_hold = 1'b0; e_done = 1'b0; e_err = 1'b0;
            exp_id = ID_WIDTH'(old_id);
            case (kind)
                0: e_err = (j == 1);
                1: e_done = (j == 1);
                2: begin
                    e_hold = (j <= 2 + d + SETTLE_CYCLES);
                    e_done = (j == last);
                    if (j >= 3 + d) exp_id = ID_WIDTH'(rid);
                end
                default: begin
                    e_hold = (j <= DRAIN_TIMEOUT);
                    e_err  = (j == last);
                end
            endcase
            exp_v = {e_hold, e_hold, ~e_hold, e_done, e_err};
            obs_v = {dp_hold, busy, req_ready, cfg_done, cfg_err};
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL %s status j=%0d: got hold/busy/ready/done/err=%b want %b", tag, j, obs_v, exp_v);
            end
            checks++;
            if (id_o !== exp_id) begin
                errors++;
                $display("FAIL %s id j=%0d: got %0d want %0d", tag, j, id_o, exp_id);
            end
            // Busy-time request noise must be ignored; release valid at IDLE.
            if (j == last || kind < 2) begin
                req_valid = 1'b0;
            end else begin
                req_valid = 1'($urandom_range(1, 0));
                req_id    = ID_WIDTH'($urandom_range(3, 0));
            end
            if (kind == 2 && j <= d)                       dp_idle = 1'b0;
            else if (kind == 2 && j == d + 1)              dp_idle = 1'b1;
            else if (kind == 3 && j < last)                dp_idle = 1'b0;
            else                                           dp_idle = 1'($urandom_range(1, 0));
        end
        if (kind == 2) model_id = rid;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if ({dp_hold, busy, req_ready, cfg_done, cfg_err} !== 5'b00100) begin
            errors++;
            $display("FAIL reset status: got %b want 00100", {dp_hold, busy, req_ready, cfg_done, cfg_err});
        end
        checks++;
        if (id_o !== ID_WIDTH'(RESET_ID)) begin
            errors++;
            $display("FAIL reset id: got %0d want %0d", id_o, RESET_ID);
        end
        model_id = RESET_ID;
    endtask

    task automatic test_directed();
        run_req(2, 0, "switch_fast");
        run_req(1, 5, "switch_drain5_to1");
        run_req(2, 5, "switch_drain5_to2");
        run_req(1, 4, "back_to_1");
        run_req(2, 100, "drain_timeout");
        run_req(0, 0, "invalid_0");
        run_req(3, 0, "invalid_3");
        run_req(1, 0, "same_id");
        run_req(2, DRAIN_TIMEOUT - 1, "drain_last_chance");
    endtask

    // Reset during SETTLE of a switch away from RESET_ID, then recover.
    task automatic test_reset_mid_settle();
        if (model_id != RESET_ID) run_req(RESET_ID, 0, "prep_reset_id");
        req_id = ID_WIDTH'(2); req_valid = 1'b1; dp_idle = 1'b1;
        @(posedge clock);
        @(negedge clock); req_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        checks++;
        if (id_o !== ID_WIDTH'(2) || dp_hold !== 1'b1) begin
            errors++;
            $display("FAIL mid_settle pre: got id=%0d hold=%b want id=2 hold=1", id_o, dp_hold);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({dp_hold, busy, req_ready, cfg_done, cfg_err, id_o} !== {5'b00100, ID_WIDTH'(RESET_ID)}) begin
            errors++;
            $display("FAIL mid_settle abort: got status=%b id=%0d want 00100 id=%0d",
                     {dp_hold, busy, req_ready, cfg_done, cfg_err}, id_o, RESET_ID);
        end
        @(negedge clock);
        reset = 1'b0;
        model_id = RESET_ID;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            checks++;
            if ({dp_hold, busy, req_ready, cfg_done, cfg_err, id_o} !== {5'b00100, ID_WIDTH'(RESET_ID)}) begin
                errors++;
                $display("FAIL mid_settle quiet k=%0d: got status=%b id=%0d", k,
                         {dp_hold, busy, req_ready, cfg_done, cfg_err}, id_o);
            end
        end
        run_req(2, 0, "after_reset_switch");
    endtask

    task automatic test_random();
        int rid, d;
        for (int n = 0; n < 40; n++) begin
            rid = $urandom_range(3, 0);
            d   = ($urandom_range(7, 0) == 0) ? $urandom_range(30, 16) : $urandom_range(8, 0);
            run_req(rid, d, "random");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_mid_settle();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
